mmio_initiator: RTL and testbench
=================================

Name: mmio_initiator

Overview:
- CPU-side initiator for the MMIO start/req/ack handshake used by the memory-mapped device block (RTC, CLINT mtimecmp).
- Accepts one load or store from the memory stage and aligns its address to 8 bytes.
- Runs the handshake to completion, extracts and extends the load data, and reports done or error back to the pipeline.
- Sits between the memory stage and the MMIO device responder; the pipeline stalls while the block is busy.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for a req edge before aborting with error.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  pipeline request strobe, sampled only when o_ready=1.
- i_ren  in  1  request is a load.
- i_wen  in  1  request is a store.
- i_addr  in  64  byte address.
- i_wdata  in  64  store data, right-aligned.
- i_size  in  2  access size: 0=byte, 1=half, 2=word, 3=dword.
- i_unsigned  in  1  zero-extend the load result (1) or sign-extend it (0).
- o_ready  out  1  idle, can accept a request.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_done: illegal request, misaligned access or timeout.
- o_rdata  out  64  extended load result, valid with o_done.
- o_start  out  1  one-cycle transaction start to the responder.
- o_ren  out  1  read enable to the responder.
- o_wen  out  1  write enable to the responder.
- o_addr  out  64  8-byte-aligned device address.
- o_wdata  out  64  store data shifted into its byte lane.
- o_wmask  out  8  byte-lane mask for stores.
- i_req  in  1  responder done / data valid, level.
- i_rdata  in  64  responder read data.
- o_ack  out  1  one-cycle acknowledge to the responder.

Behaviour:
- Reset: state=IDLE. o_start, o_ren, o_wen, o_ack, o_done, o_err = 0. o_addr, o_wdata, o_wmask, o_rdata = 0. Counter = 0.
- States: IDLE, START, WAIT_REQ, ACK, WAIT_DROP, FAIL.
- o_ready = (state==IDLE).
- IDLE, on i_valid:
  - Exactly one of i_ren/i_wen set and i_addr[2:0] aligned to the size → latch the request and go to START.
  - Otherwise (both set, neither set, or misaligned) → go to FAIL. No bus activity occurs.
- Store data and mask at latch:
  - offset = i_addr[2:0].
  - o_addr = {i_addr[63:3], 3'b000}.
  - o_wdata = i_wdata << (offset*8).
  - o_wmask = ((1<<(1<<size))-1) << offset, truncated to 8 bits.
- START:
  - o_start=1 for exactly this one cycle.
  - o_ren/o_wen are asserted from this cycle until the cycle i_req is sampled high.
  - Go to WAIT_REQ; counter cleared.
- WAIT_REQ:
  - i_req=1 → capture i_rdata into a raw register, drop o_ren/o_wen, go to ACK.
  - Otherwise increment the counter. When counter==TIMEOUT → go to FAIL.
- ACK: o_ack=1 for this one cycle; go to WAIT_DROP; counter cleared.
- WAIT_DROP:
  - Wait for i_req=0 (the responder clears req one cycle after ack).
  - On i_req=0 → o_done=1, o_err=0, o_rdata driven, go to IDLE.
  - Timeout rule as in WAIT_REQ.
- FAIL: o_done=1, o_err=1, o_rdata=0 for one cycle; go to IDLE.
- Load extraction:
  - s = raw >> (offset*8).
  - Take the low 8/16/32/64 bits per size.
  - Sign-extend from the top bit unless i_unsigned=1. For size 3, i_unsigned is ignored.
  - Store completions return o_rdata=0.
- Latency against the standard responder, request accepted in cycle T:
  - o_start in T+1.
  - i_req seen in T+2.
  - o_ack in T+3.
  - o_done in T+4.
- i_valid is ignored while state≠IDLE. The pipeline holds the request until o_done.
- A new request may be accepted in the cycle after o_done.
- o_start is never reasserted while i_req=1 from a previous transaction.
- Reset mid-operation: immediate return to IDLE, all handshake outputs 0 in the next cycle. No o_done is produced for the aborted access.
- Counter saturates; it never wraps.

Test Plan:
- Dword load at 0x0200_BFF8 (RTC), responder returns 0x1122334455667788 → o_start at T+1, o_ack at T+3, o_done at T+4, o_rdata=0x1122334455667788, o_err=0.
- Signed byte load at 0x...BFFF, raw data 0x80xx..xx → o_rdata=0xFFFFFFFFFFFFFF80. Same access with i_unsigned=1 → 0x80.
- Word store 0xDEADBEEF at 0x0200_4004 → o_addr=0x0200_4000, o_wdata=0xDEADBEEF_00000000, o_wmask=0xF0, o_wen=1 until req, done with o_err=0.
- Half load at an odd address, and a request with i_ren=i_wen=1 → no o_start; o_done+o_err in T+1.
- Responder never raises req → o_done+o_err after TIMEOUT cycles in WAIT_REQ, o_rdata=0, then o_ready=1.
- rst asserted in WAIT_REQ, and back-to-back loads (second i_valid held high) → reset returns to IDLE with no done pulse; the second load is accepted the cycle after the first o_done, and o_start is never asserted while i_req=1.

Source files
------------

// File: rtl/mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mmio_initiator
// Brief    : CPU-side initiator for the MMIO start/req/ack device handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_initiator #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [63:0] o_rdata,
    output logic        o_start,
    output logic        o_ren,
    output logic        o_wen,
    output logic [63:0] o_addr,
    output logic [63:0] o_wdata,
    output logic [7:0]  o_wmask,
    input  logic        i_req,
    input  logic [63:0] i_rdata,
    output logic        o_ack
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_REQ  = 3'd2,
        S_ACK       = 3'd3,
        S_WAIT_DROP = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              start_q;
    logic              ren_q;
    logic              wen_q;
    logic              ack_q;
    logic [63:0]       addr_q;
    logic [63:0]       wdata_q;
    logic [7:0]        wmask_q;
    logic [63:0]       rdata_q;
    logic [1:0]        size_q;
    logic [2:0]        off_q;
    logic              uns_q;

    logic              w_aligned;
    logic              w_legal;
    logic              w_cnt_expired;
    logic [7:0]        w_mask_base;
    logic [63:0]       w_shifted;
    logic [63:0]       w_extracted;
    logic              w_drop_done;

    always_comb begin
        w_aligned   = 1'b1;
        w_mask_base = 8'h01;
        case (i_size)
            2'd0: begin
                w_aligned   = 1'b1;
                w_mask_base = 8'h01;
            end
            2'd1: begin
                w_aligned   = (i_addr[0] == 1'b0);
                w_mask_base = 8'h03;
            end
            2'd2: begin
                w_aligned   = (i_addr[1:0] == 2'b00);
                w_mask_base = 8'h0F;
            end
            default: begin
                w_aligned   = (i_addr[2:0] == 3'b000);
                w_mask_base = 8'hFF;
            end
        endcase
    end

    assign w_legal = (i_ren ^ i_wen) & w_aligned;

    // Extraction works on the live responder data so the extended result is
    // registered in the same edge that captures it.
    always_comb begin
        w_shifted   = i_rdata >> {off_q, 3'b000};
        w_extracted = w_shifted;
        case (size_q)
            2'd0: w_extracted = uns_q ? {56'd0, w_shifted[7:0]}
                                      : {{56{w_shifted[7]}}, w_shifted[7:0]};
            2'd1: w_extracted = uns_q ? {48'd0, w_shifted[15:0]}
                                      : {{48{w_shifted[15]}}, w_shifted[15:0]};
            2'd2: w_extracted = uns_q ? {32'd0, w_shifted[31:0]}
                                      : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: w_extracted = w_shifted;
        endcase
    end

    assign cnt_d         = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign w_cnt_expired = (cnt_d == C_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ack_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
            uns_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        if (!w_legal) begin
                            state_q <= S_FAIL;
                        end else if (!i_req) begin
                            // A stale req from an aborted access must clear first.
                            addr_q  <= {i_addr[63:3], 3'b000};
                            wdata_q <= i_wdata << {i_addr[2:0], 3'b000};
                            wmask_q <= w_mask_base << i_addr[2:0];
                            size_q  <= i_size;
                            off_q   <= i_addr[2:0];
                            uns_q   <= i_unsigned;
                            start_q <= 1'b1;
                            ren_q   <= i_ren;
                            wen_q   <= i_wen;
                            state_q <= S_START;
                        end
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_REQ;
                end
                S_WAIT_REQ: begin
                    if (i_req) begin
                        rdata_q <= ren_q ? w_extracted : 64'd0;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_d;
                        if (w_cnt_expired) begin
                            ren_q   <= 1'b0;
                            wen_q   <= 1'b0;
                            state_q <= S_FAIL;
                        end
                    end
                end
                S_ACK: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_DROP;
                end
                S_WAIT_DROP: begin
                    if (!i_req) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (w_cnt_expired) begin
                            state_q <= S_FAIL;
                        end
                    end
                end
                S_FAIL: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Completion is decoded from the req drop so it lands in the same cycle.
    assign w_drop_done = (state_q == S_WAIT_DROP) && !i_req;

    assign o_ready = (state_q == S_IDLE);
    assign o_done  = w_drop_done || (state_q == S_FAIL);
    assign o_err   = (state_q == S_FAIL);
    assign o_rdata = w_drop_done ? rdata_q : 64'd0;
    assign o_start = start_q;
    assign o_ren   = ren_q;
    assign o_wen   = wen_q;
    assign o_ack   = ack_q;
    assign o_addr  = addr_q;
    assign o_wdata = wdata_q;
    assign o_wmask = wmask_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_initiator
// Brief    : Directed self-checking bench with a schedule-based output model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_initiator;

    localparam int TO = 255;
    localparam int N  = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ren, i_wen, i_unsigned, i_req;
    logic [63:0] i_addr, i_wdata, i_rdata;
    logic [1:0]  i_size;
    logic        o_ready, o_done, o_err, o_start, o_ren, o_wen, o_ack;
    logic [63:0] o_rdata, o_addr, o_wdata;
    logic [7:0]  o_wmask;

    mmio_initiator #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ren(i_ren), .i_wen(i_wen),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_size(i_size), .i_unsigned(i_unsigned),
        .o_ready(o_ready), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
        .o_start(o_start), .o_ren(o_ren), .o_wen(o_wen), .o_addr(o_addr),
        .o_wdata(o_wdata), .o_wmask(o_wmask), .i_req(i_req), .i_rdata(i_rdata),
        .o_ack(o_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Expected per-cycle behaviour, filled by the model when a request is issued.
    bit          exp_busy [N];
    bit          exp_start[N];
    bit          exp_ack  [N];
    bit          exp_ren  [N];
    bit          exp_wen  [N];
    bit          exp_done [N];
    bit          exp_err  [N];
    bit          exp_bus  [N];
    bit          exp_wbus [N];
    logic [63:0] exp_rd   [N];
    logic [63:0] exp_addr [N];
    logic [63:0] exp_wd   [N];
    logic [7:0]  exp_wm   [N];

    logic [63:0] resp_data = '0;
    bit          resp_mute = 1'b0;

    int          acc_t, obs_s, obs_a, obs_d;
    logic [63:0] got_rdata, got_addr, got_wdata;
    logic [7:0]  got_wmask;
    logic        got_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] raw, input int off,
                                               input int size, input bit uns);
        int          bits;
        logic [63:0] v, lim;
        bits = 8 << size;
        v    = raw >> (off * 8);
        if (bits < 64) begin
            lim = 64'd1 << bits;
            v   = v % lim;
            if (!uns && v >= (lim >> 1)) v = v - lim;
        end
        return v;
    endfunction

    // Standard responder: req one cycle after start, cleared one cycle after ack.
    initial begin
        logic s_start, s_ack;
        i_req   = 1'b0;
        i_rdata = '0;
        forever begin
            @(negedge clk);
            s_start = o_start;
            s_ack   = o_ack;
            @(posedge clk);
            #1;
            if (rst) i_req = 1'b0;
            else if (s_start && !resp_mute) begin
                i_req   = 1'b1;
                i_rdata = resp_data;
            end else if (s_ack) i_req = 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && cyc < N) begin
                chk("ready", o_ready, !exp_busy[cyc]);
                chk("start", o_start, exp_start[cyc]);
                chk("ack",   o_ack,   exp_ack[cyc]);
                chk("ren",   o_ren,   exp_ren[cyc]);
                chk("wen",   o_wen,   exp_wen[cyc]);
                chk("done",  o_done,  exp_done[cyc]);
                chk("start_while_req", o_start & i_req, 0);
                if (exp_done[cyc]) begin
                    chk("err",   o_err,   exp_err[cyc]);
                    chk("rdata", o_rdata, exp_rd[cyc]);
                end
                if (exp_bus[cyc]) chk("addr", o_addr, exp_addr[cyc]);
                if (exp_wbus[cyc]) begin
                    chk("wdata", o_wdata, exp_wd[cyc]);
                    chk("wmask", o_wmask, exp_wm[cyc]);
                end
            end
        end
    end

    task automatic do_req(input bit ren, input bit wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input int size, input bit uns,
                          input logic [63:0] raw, input bit keep);
        int         t, d, off, nb;
        bit         legal;
        logic [7:0] m;
        i_valid = 1'b1; i_ren = ren; i_wen = wen; i_addr = addr; i_wdata = wdata;
        i_size = size[1:0]; i_unsigned = uns; resp_data = raw;
        t     = cyc;
        acc_t = t;
        off   = int'(addr % 8);
        nb    = 1 << size;
        legal = (ren != wen) && ((addr % nb) == 0);
        for (int b = 0; b < 8; b++) m[b] = (b >= off) && (b < off + nb);
        if (!legal) begin
            d = t + 1;
            exp_err[d] = 1'b1;
            exp_rd[d]  = '0;
        end else begin
            d = resp_mute ? t + 2 + TO : t + 4;
            exp_start[t+1] = 1'b1;
            for (int c = t + 1; c <= (resp_mute ? d - 1 : t + 2); c++) begin
                exp_ren[c] = ren;
                exp_wen[c] = wen;
            end
            if (!resp_mute) exp_ack[t+3] = 1'b1;
            exp_err[d] = resp_mute;
            exp_rd[d]  = (resp_mute || wen) ? 64'd0 : model_load(raw, off, size, uns);
            for (int c = t + 1; c <= d; c++) begin
                exp_bus[c]  = 1'b1;
                exp_addr[c] = addr & ~64'h7;
                exp_wbus[c] = wen;
                exp_wd[c]   = wdata << (off * 8);
                exp_wm[c]   = m;
            end
        end
        exp_done[d] = 1'b1;
        for (int c = t + 1; c <= d; c++) exp_busy[c] = 1'b1;

        obs_s = -1; obs_a = -1; obs_d = -1;
        got_rdata = '1; got_err = 1'bx;
        @(negedge clk);
        forever begin
            if (o_start && obs_s < 0) obs_s = cyc - t;
            if (o_ack && obs_a < 0) obs_a = cyc - t;
            if (o_done && obs_d < 0) begin
                obs_d = cyc - t; got_rdata = o_rdata; got_err = o_err;
            end
            if (cyc == t + 1) begin
                got_addr = o_addr; got_wdata = o_wdata; got_wmask = o_wmask;
            end
            if (cyc >= d) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (!keep) i_valid = 1'b0;
    endtask

    initial begin
        int d1;
        rst = 1'b1; i_valid = 1'b0; i_ren = 1'b0; i_wen = 1'b0; i_addr = '0;
        i_wdata = '0; i_size = '0; i_unsigned = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_start", o_start, 0);
        chk("rst_done",  o_done,  0);
        chk("rst_err",   o_err,   0);
        chk("rst_addr",  o_addr,  0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_wmask", o_wmask, 0);
        chk("rst_rdata", o_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        do_req(1, 0, 64'h0200_BFF8, 0, 3, 0, 64'h1122_3344_5566_7788, 0);
        chk("dword_rdata", got_rdata, 64'h1122_3344_5566_7788);
        chk("dword_err", got_err, 0);
        chk("dword_start_lat", obs_s, 1);
        chk("dword_ack_lat", obs_a, 3);
        chk("dword_done_lat", obs_d, 4);

        do_req(1, 0, 64'h0200_BFFF, 0, 0, 0, 64'h80AB_CDEF_0123_4567, 0);
        chk("sbyte_rdata", got_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        do_req(1, 0, 64'h0200_BFFF, 0, 0, 1, 64'h80AB_CDEF_0123_4567, 0);
        chk("ubyte_rdata", got_rdata, 64'h80);

        do_req(0, 1, 64'h0200_4004, 64'hDEAD_BEEF, 2, 0, 64'h5555_5555_5555_5555, 0);
        chk("sw_addr", got_addr, 64'h0200_4000);
        chk("sw_wdata", got_wdata, 64'hDEAD_BEEF_0000_0000);
        chk("sw_wmask", got_wmask, 8'hF0);
        chk("sw_err", got_err, 0);
        chk("sw_rdata", got_rdata, 0);

        do_req(1, 0, 64'h0200_4001, 0, 1, 0, 64'h0, 0);
        chk("mis_done_lat", obs_d, 1);
        chk("mis_err", got_err, 1);
        chk("mis_nostart", obs_s, -1);
        do_req(1, 1, 64'h0200_4000, 0, 3, 0, 64'h0, 0);
        chk("both_err", got_err, 1);
        chk("both_nostart", obs_s, -1);
        do_req(0, 0, 64'h0200_4000, 0, 3, 0, 64'h0, 0);
        chk("none_err", got_err, 1);

        do_req(1, 0, 64'h0200_4002, 0, 1, 0, 64'h0000_0000_8001_0000, 0);
        chk("shalf_rdata", got_rdata, 64'hFFFF_FFFF_FFFF_8001);
        do_req(1, 0, 64'h0200_4004, 0, 2, 0, 64'h7FFF_FFFF_0000_0000, 0);
        chk("sword_pos", got_rdata, 64'h7FFF_FFFF);
        do_req(1, 0, 64'h0200_4000, 0, 2, 0, 64'h0000_0000_9000_0001, 0);
        chk("sword_neg", got_rdata, 64'hFFFF_FFFF_9000_0001);
        do_req(0, 1, 64'h0200_4005, 64'hA5, 0, 0, 64'h0, 0);
        chk("sb_wdata", got_wdata, 64'h0000_A500_0000_0000);
        chk("sb_wmask", got_wmask, 8'h20);

        resp_mute = 1'b1;
        do_req(1, 0, 64'h0200_BFF8, 0, 3, 0, 64'h1234, 0);
        chk("to_done_lat", obs_d, TO + 2);
        chk("to_err", got_err, 1);
        chk("to_rdata", got_rdata, 0);

        // Reset while waiting for req: no completion, everything back to idle.
        i_valid = 1'b1; i_ren = 1'b1; i_wen = 1'b0; i_addr = 64'h0200_BFF8; i_size = 2'd3;
        acc_t = cyc;
        exp_start[acc_t+1] = 1'b1;
        for (int c = acc_t + 1; c <= acc_t + 4; c++) begin
            exp_ren[c] = 1'b1; exp_busy[c] = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1; rst = 1'b1; i_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", o_ready, 1);
        chk("mid_rst_ren", o_ren, 0);
        chk("mid_rst_addr", o_addr, 0);
        @(posedge clk); #1;
        resp_mute = 1'b0;
        @(posedge clk); #1;

        do_req(1, 0, 64'h0200_4000, 0, 3, 0, 64'h0102_0304_0506_0708, 1);
        chk("b2b1_rdata", got_rdata, 64'h0102_0304_0506_0708);
        d1 = acc_t + obs_d;
        do_req(1, 0, 64'h0200_4004, 0, 2, 1, 64'hCAFE_F00D_1234_5678, 0);
        chk("b2b2_rdata", got_rdata, 64'hCAFE_F00D);
        chk("b2b_gap", (acc_t + obs_s) - d1, 2);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
